// File: rtl/register_bank_wb_pkg.sv
// Shared constants and the dump FSM state encoding for the MIPS register bank.
package register_bank_wb_pkg;

    localparam int NB_DATA = 32;
    localparam int NB_ADDR = 5;
    localparam int N_REGS  = 32;

    // r0 is hard-wired to zero in MIPS
    localparam logic [NB_ADDR-1:0] REG_ZERO = '0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_DUMP = 2'b01,
        ST_DONE = 2'b10
    } dump_state_e;

endpackage

// File: rtl/register_bank_wb_dump_seq.sv
// Debug dump sequencer: walks every register index once, one per cycle,
// and registers the bypassed value it reads back from the bank.
module regbank_dump_seq #(
    parameter int NB_DATA = 32,
    parameter int NB_ADDR = 5,
    parameter int N_REGS  = 32
) (
    input  logic               clock_i,
    input  logic               reset_i,
    input  logic               dump_start_i,
    output logic [NB_ADDR-1:0] rd_addr_o,
    input  logic [NB_DATA-1:0] rd_data_i,
    output logic               dump_valid_o,
    output logic [NB_ADDR-1:0] dump_addr_o,
    output logic [NB_DATA-1:0] dump_data_o,
    output logic               dump_done_o,
    output logic               dump_busy_o
);
    import register_bank_wb_pkg::*;

    // One extra bit so the terminal compare never sees a wrapped value
    localparam logic [NB_ADDR:0] CNT_LAST = (NB_ADDR+1)'(N_REGS - 1);

    dump_state_e        state_q;
    logic [NB_ADDR:0]   cnt_q;
    logic               valid_q;
    logic [NB_ADDR-1:0] addr_q;
    logic [NB_DATA-1:0] data_q;
    logic               done_q;

    assign rd_addr_o    = cnt_q[NB_ADDR-1:0];
    assign dump_valid_o = valid_q;
    assign dump_addr_o  = addr_q;
    assign dump_data_o  = data_q;
    assign dump_done_o  = done_q;
    assign dump_busy_o  = (state_q != ST_IDLE);

    // Dump FSM: IDLE waits for start, DUMP emits one register per edge,
    // DONE spends one edge raising the done pulse and one edge dropping it.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (dump_start_i) begin
                        state_q <= ST_DUMP;
                        cnt_q   <= '0;
                    end
                end
                ST_DUMP: begin
                    valid_q <= 1'b1;
                    addr_q  <= cnt_q[NB_ADDR-1:0];
                    data_q  <= rd_data_i;
                    cnt_q   <= cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        state_q <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (!done_q) begin
                        valid_q <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        done_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: rtl/register_bank_wb.sv
// MIPS general-purpose register file: one write port fed by the write-back
// mux, two combinational operand ports with write-through bypass, and a
// sequential debug dump port.
module register_bank_wb #(
    parameter int NB_DATA = 32,
    parameter int NB_ADDR = 5,
    parameter int N_REGS  = 32
) (
    input  logic               clock_i,
    input  logic               reset_i,
    input  logic               reg_write_i,
    input  logic [NB_ADDR-1:0] write_addr_i,
    input  logic [NB_DATA-1:0] write_data_i,
    input  logic [NB_ADDR-1:0] read_addr_a_i,
    input  logic [NB_ADDR-1:0] read_addr_b_i,
    output logic [NB_DATA-1:0] data_a_o,
    output logic [NB_DATA-1:0] data_b_o,
    input  logic               dump_start_i,
    output logic               dump_valid_o,
    output logic [NB_ADDR-1:0] dump_addr_o,
    output logic [NB_DATA-1:0] dump_data_o,
    output logic               dump_done_o,
    output logic               dump_busy_o
);
    import register_bank_wb_pkg::*;

    localparam int N_PORTS = 3;   // port A, port B, dump sequencer
    localparam logic [NB_ADDR-1:0] ADDR_ZERO = NB_ADDR'(REG_ZERO);

    logic [NB_DATA-1:0] regs_q [N_REGS];
    logic [NB_ADDR-1:0] rd_addr [N_PORTS];
    logic [NB_DATA-1:0] rd_data [N_PORTS];
    logic [NB_ADDR-1:0] dump_rd_addr;

    // Register array write; r0 is never written so it stays at zero
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            for (int i = 0; i < N_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (reg_write_i && (write_addr_i != ADDR_ZERO)) begin
            regs_q[write_addr_i] <= write_data_i;
        end
    end

    assign rd_addr[0] = read_addr_a_i;
    assign rd_addr[1] = read_addr_b_i;
    assign rd_addr[2] = dump_rd_addr;

    // Every read port sees the same rule: r0 reads zero, a same-cycle write
    // to the addressed register is forwarded, otherwise the stored value.
    genvar gi;
    generate
        for (gi = 0; gi < N_PORTS; gi++) begin : g_rd
            assign rd_data[gi] = (rd_addr[gi] == ADDR_ZERO) ? '0 :
                                 (reg_write_i && (write_addr_i == rd_addr[gi])) ? write_data_i :
                                 regs_q[rd_addr[gi]];
        end
    endgenerate

    assign data_a_o = rd_data[0];
    assign data_b_o = rd_data[1];

    regbank_dump_seq #(
        .NB_DATA (NB_DATA),
        .NB_ADDR (NB_ADDR),
        .N_REGS  (N_REGS)
    ) u_dump_seq (
        .clock_i      (clock_i),
        .reset_i      (reset_i),
        .dump_start_i (dump_start_i),
        .rd_addr_o    (dump_rd_addr),
        .rd_data_i    (rd_data[2]),
        .dump_valid_o (dump_valid_o),
        .dump_addr_o  (dump_addr_o),
        .dump_data_o  (dump_data_o),
        .dump_done_o  (dump_done_o),
        .dump_busy_o  (dump_busy_o)
    );

endmodule

// File: tb/tb_register_bank_wb.sv
// Self-checking bench for register_bank_wb: directed scenarios plus random
// traffic, all compared against a behavioural model of the register file.
module tb_register_bank_wb;

    logic        clock_i = 1'b0;
    logic        reset_i;
    logic        reg_write_i;
    logic [4:0]  write_addr_i;
    logic [31:0] write_data_i;
    logic [4:0]  read_addr_a_i;
    logic [4:0]  read_addr_b_i;
    logic [31:0] data_a_o;
    logic [31:0] data_b_o;
    logic        dump_start_i;
    logic        dump_valid_o;
    logic [4:0]  dump_addr_o;
    logic [31:0] dump_data_o;
    logic        dump_done_o;
    logic        dump_busy_o;

    register_bank_wb dut (
        .clock_i       (clock_i),
        .reset_i       (reset_i),
        .reg_write_i   (reg_write_i),
        .write_addr_i  (write_addr_i),
        .write_data_i  (write_data_i),
        .read_addr_a_i (read_addr_a_i),
        .read_addr_b_i (read_addr_b_i),
        .data_a_o      (data_a_o),
        .data_b_o      (data_b_o),
        .dump_start_i  (dump_start_i),
        .dump_valid_o  (dump_valid_o),
        .dump_addr_o   (dump_addr_o),
        .dump_data_o   (dump_data_o),
        .dump_done_o   (dump_done_o),
        .dump_busy_o   (dump_busy_o)
    );

    always #5 clock_i = ~clock_i;

    int tests = 0;
    int fails = 0;

    // Behavioural model
    logic [31:0] m_regs [32];
    logic        m_busy;
    int          m_edge;      // edges since the start edge of the current dump
    logic        m_valid;
    logic        m_done;
    logic [4:0]  m_addr;
    logic [31:0] m_data;

    // Observations of the DUT dump port, for literal checks
    int          n_valid;
    int          n_done;
    int          seen_cnt  [32];
    logic [31:0] seen_data [32];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] m_read(input logic [4:0] a);
        if (a == 5'd0) return 32'h0;
        if (reg_write_i && write_addr_i == a) return write_data_i;
        return m_regs[a];
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
        m_busy  = 1'b0;
        m_edge  = 0;
        m_valid = 1'b0;
        m_done  = 1'b0;
        m_addr  = 5'd0;
        m_data  = 32'h0;
    endtask

    task automatic clear_stats();
        n_valid = 0;
        n_done  = 0;
        for (int i = 0; i < 32; i++) begin
            seen_cnt[i]  = 0;
            seen_data[i] = 32'h0;
        end
    endtask

    // One clock cycle: drive inputs, check operand reads before the edge,
    // advance the model across the edge, check the dump port after it.
    task automatic step(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                        input logic [4:0] ra, input logic [4:0] rb, input logic st);
        reg_write_i   = we;
        write_addr_i  = wa;
        write_data_i  = wd;
        read_addr_a_i = ra;
        read_addr_b_i = rb;
        dump_start_i  = st;
        #1;
        check("read_a", data_a_o, m_read(ra));
        check("read_b", data_b_o, m_read(rb));
        @(posedge clock_i);
        if (m_busy) begin
            m_edge++;
            if (m_edge <= 32) begin
                m_valid = 1'b1;
                m_addr  = 5'(m_edge - 1);
                m_data  = m_read(5'(m_edge - 1));
            end else if (m_edge == 33) begin
                m_valid = 1'b0;
                m_done  = 1'b1;
            end else begin
                m_done  = 1'b0;
                m_busy  = 1'b0;
            end
        end else if (st) begin
            m_busy = 1'b1;
            m_edge = 0;
        end
        if (we && wa != 5'd0) m_regs[wa] = wd;
        #1;
        check("dump_valid", {31'b0, dump_valid_o}, {31'b0, m_valid});
        check("dump_done",  {31'b0, dump_done_o},  {31'b0, m_done});
        check("dump_busy",  {31'b0, dump_busy_o},  {31'b0, m_busy});
        if (m_valid) begin
            check("dump_addr", {27'b0, dump_addr_o}, {27'b0, m_addr});
            check("dump_data", dump_data_o, m_data);
        end
        if (dump_valid_o) begin
            n_valid++;
            seen_cnt[dump_addr_o]++;
            seen_data[dump_addr_o] = dump_data_o;
        end
        if (dump_done_o) n_done++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 5'd0, 32'h0, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 1'b0);
    endtask

    // Reset pulse between clock edges; everything must clear with no edge
    task automatic reset_pulse(input logic [4:0] ra);
        @(negedge clock_i);
        reg_write_i   = 1'b0;
        dump_start_i  = 1'b0;
        read_addr_a_i = ra;
        reset_i       = 1'b1;
        #1;
        m_reset();
        check("rst_read_a", data_a_o, 32'h0);
        check("rst_valid", {31'b0, dump_valid_o}, 32'h0);
        check("rst_busy",  {31'b0, dump_busy_o},  32'h0);
        check("rst_done",  {31'b0, dump_done_o},  32'h0);
        check("rst_addr",  {27'b0, dump_addr_o},  32'h0);
        check("rst_data",  dump_data_o,           32'h0);
        #1;
        reset_i = 1'b0;
    endtask

    initial begin
        reset_i       = 1'b1;
        reg_write_i   = 1'b0;
        write_addr_i  = 5'd0;
        write_data_i  = 32'h0;
        read_addr_a_i = 5'd0;
        read_addr_b_i = 5'd0;
        dump_start_i  = 1'b0;
        m_reset();
        clear_stats();
        #2;
        reset_i = 1'b0;
        check("init_busy", {31'b0, dump_busy_o}, 32'h0);
        check("init_valid", {31'b0, dump_valid_o}, 32'h0);

        // Reset clears a written register with no clock edge
        step(1'b1, 5'd5, 32'hDEADBEEF, 5'd0, 5'd0, 1'b0);
        step(1'b0, 5'd0, 32'h0, 5'd5, 5'd5, 1'b0);
        check("r5_written", data_a_o, 32'hDEADBEEF);
        reset_pulse(5'd5);

        // r0 protection, during and after the write cycle
        step(1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0, 1'b0);
        step(1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b0);
        check("r0_a_after", data_a_o, 32'h0);
        check("r0_b_after", data_b_o, 32'h0);

        // Bypass on both ports, then stored value after the edge
        reg_write_i = 1'b1; write_addr_i = 5'd7; write_data_i = 32'h12345678;
        read_addr_a_i = 5'd7; read_addr_b_i = 5'd7;
        #1;
        check("bypass_a", data_a_o, 32'h12345678);
        check("bypass_b", data_b_o, 32'h12345678);
        step(1'b1, 5'd7, 32'h12345678, 5'd7, 5'd7, 1'b0);
        step(1'b0, 5'd0, 32'h0, 5'd7, 5'd7, 1'b0);
        check("stored_a", data_a_o, 32'h12345678);
        check("stored_b", data_b_o, 32'h12345678);

        // Full dump of a known pattern
        for (int n = 1; n < 32; n++) step(1'b1, 5'(n), 32'h01010101 * n, 5'd0, 5'd0, 1'b0);
        clear_stats();
        step(1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b1);
        idle(40);
        check("full_n_valid", n_valid, 32);
        check("full_n_done", n_done, 1);
        check("full_r0", seen_data[0], 32'h0);
        check("full_r1", seen_data[1], 32'h01010101);
        check("full_r31", seen_data[31], 32'h1F1F1F1F);
        check("full_busy_end", {31'b0, dump_busy_o}, 32'h0);

        // Start pulses while busy (index 3 and during DONE) are ignored
        clear_stats();
        for (int i = 0; i < 45; i++)
            step(1'b0, 5'd0, 32'h0, 5'd3, 5'd9, (i == 0) || (i == 4) || (i == 33) || (i == 34));
        check("busy_n_valid", n_valid, 32);
        check("busy_n_done", n_done, 1);
        check("busy_cnt_r3", seen_cnt[3], 1);

        // Writes during a dump: bypass into word 20, no re-emit of r2
        clear_stats();
        for (int i = 0; i < 40; i++) begin
            if (i == 21)      step(1'b1, 5'd20, 32'hAAAA0000, 5'd0, 5'd0, 1'b0);
            else if (i == 26) step(1'b1, 5'd2, 32'h00000055, 5'd0, 5'd0, 1'b0);
            else              step(1'b0, 5'd0, 32'h0, 5'd0, 5'd0, i == 0);
        end
        check("wdump_r20", seen_data[20], 32'hAAAA0000);
        check("wdump_r2_cnt", seen_cnt[2], 1);
        check("wdump_r2_old", seen_data[2], 32'h02020202);
        step(1'b0, 5'd0, 32'h0, 5'd2, 5'd0, 1'b0);
        check("wdump_r2_read", data_a_o, 32'h00000055);

        // Reset at dump index 10, then a fresh dump starts at r0
        step(1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b1);
        for (int i = 0; i < 11; i++) step(1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b0);
        check("mid_idx10", {27'b0, dump_addr_o}, 32'd10);
        reset_pulse(5'd10);
        step(1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b1);
        step(1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b0);
        check("restart_valid", {31'b0, dump_valid_o}, 32'h1);
        check("restart_addr", {27'b0, dump_addr_o}, 32'h0);
        idle(40);

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 499) == 0) reset_pulse(5'($urandom_range(0, 31)));
            step($urandom_range(0, 1) == 1, 5'($urandom_range(0, 31)), $urandom,
                 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                 $urandom_range(0, 19) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/register_bank_wb.md
Name: register_bank_wb

Overview:
- MIPS general-purpose register file; it is the write-back target of the write-register data mux.
- Accepts the selected write-back word on a single write port and serves two combinational operand read ports to decode, with write-through bypass.
- Provides a sequential debug dump port that streams every register, one per cycle, to the debug unit.

Parameters:
- NB_DATA, 32, register width in bits
- NB_ADDR, 5, register address width
- N_REGS, 32, number of registers; must equal 2**NB_ADDR

Ports:
- clock_i  in  1  system clock, rising edge
- reset_i  in  1  asynchronous, active-high reset
- reg_write_i  in  1  write enable from the WB stage
- write_addr_i  in  NB_ADDR  destination register
- write_data_i  in  NB_DATA  write-back word, driven by the write-register mux output
- read_addr_a_i  in  NB_ADDR  rs address
- read_addr_b_i  in  NB_ADDR  rt address
- data_a_o  out  NB_DATA  rs operand
- data_b_o  out  NB_DATA  rt operand
- dump_start_i  in  1  single-cycle request to start a register dump
- dump_valid_o  out  1  dump_data_o/dump_addr_o are valid this cycle
- dump_addr_o  out  NB_ADDR  index of the register being dumped
- dump_data_o  out  NB_DATA  dumped register value
- dump_done_o  out  1  one-cycle pulse after the last register
- dump_busy_o  out  1  high while in DUMP or DONE

Behaviour:
- Reset (async, any time, including mid-dump):
  - all registers clear to 0
  - FSM goes to IDLE; counter = 0
  - dump_valid_o, dump_done_o and dump_busy_o = 0; dump_addr_o = 0; dump_data_o = 0
- Write: on a rising edge with reg_write_i=1 and write_addr_i!=0, regs[write_addr_i] <= write_data_i. Writes to r0 are discarded.
- Reads are combinational, zero latency:
  - data_x_o = 0 when the address is 0
  - else write_data_i when reg_write_i=1 and write_addr_i equals the read address (bypass)
  - else regs[addr]
  - The same rule applies independently to port A and port B, including both addressing the same register.
- Dump FSM, states IDLE, DUMP, DONE:
  - IDLE: a rising edge with dump_start_i=1 moves to DUMP with cnt=0. dump_start_i is ignored in DUMP and DONE.
  - DUMP: each edge registers dump_data_o <= bypassed value of regs[cnt], dump_addr_o <= cnt, dump_valid_o <= 1, cnt <= cnt+1. The edge that emits cnt=N_REGS-1 moves to DONE.
  - DONE: the next edge sets dump_valid_o=0 and dump_done_o=1. The edge after that clears dump_done_o and returns to IDLE.
  - Latency: start sampled at edge k; r0 is visible after edge k+1; r31 after edge k+32; done high after edge k+33.
  - The counter is NB_ADDR+1 bits wide, so the terminal compare never wraps.
- Writes stay enabled during a dump.
  - A write on the same edge that samples register cnt for dump is reflected in that dump word (bypass).
  - A write to a register already dumped is not re-emitted.
- dump_busy_o = 1 in DUMP and DONE.
- Operand read ports are fully independent of the dump FSM.

Decomposition:
- Shared package holds:
  - NB_DATA, NB_ADDR, N_REGS
  - REG_ZERO address constant
  - dump FSM state encoding (IDLE=2'b00, DUMP=2'b01, DONE=2'b10)
- One natural sub-module: regbank_dump_seq, containing the FSM, the counter and the registered dump outputs. It drives a read address into the bank and receives the bypassed data.
- Storage array and read/bypass logic stay in register_bank_wb.

Test Plan:
- Reset mid-operation:
  - stimulus: write r5=0xDEADBEEF, then pulse reset_i between clock edges
  - required: data_a_o (addr 5) reads 0 immediately, with no clock edge
  - stimulus: start a dump, assert reset_i at dump index 10
  - required: valid, busy and done all 0 at once; next start dumps from r0
- r0 protection: write r0=0xFFFFFFFF -> data_a_o and data_b_o at addr 0 read 0 both in the write cycle and after it.
- Bypass:
  - stimulus: reg_write_i=1, write_addr_i=7, write_data_i=0x12345678, read_addr_a_i=read_addr_b_i=7 in the same cycle
  - required: both ports output 0x12345678 before the edge
  - after the edge, with reg_write_i=0, both ports still output 0x12345678
- Full dump:
  - stimulus: preload rN=N*0x01010101 for N=1..31, then pulse dump_start_i
  - required: 32 consecutive valid cycles, with addr 0..31 and data 0, 0x01010101, ..., 0x1F1F1F1F
  - then exactly one dump_done_o pulse, then busy=0
- Start while busy: re-pulse dump_start_i at dump index 3 and again during DONE -> neither is honoured; sequence is unchanged; no second dump follows.
- Write during dump:
  - stimulus: write r20=0xAAAA0000 on the edge that samples index 20
  - required: dump word 20 = 0xAAAA0000
  - stimulus: write r2=0x55 at index 25
  - required: no re-emit of r2; data_a_o at addr 2 later reads 0x55
